vga_sync_strobe_gen: RTL and testbench

- Generates 640x480@60 VGA raster timing as set/clear strobe pairs for the downstream hsync/vsync SR latches.
- Also drives registered sync levels, pixel coordinates, `video_on` and a frame-start pulse.
- Sits between the pixel-clock-enable divider and the sync latches and pixel pipeline.
- Drives the set/reset side of the latch protocol; a latch fed by its strobes reproduces `hsync`/`vsync`.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_axis_seq.sv | 103 ++++++++++
 rtl/vga_sync_strobe_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_strobe_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and the per-axis phase type.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Position counters are 10 bits wide, so neither axis may exceed 1024.
    localparam int unsigned POS_W     = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } sync_phase_t;

    // Phase order along one axis: VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE.
    function automatic sync_phase_t next_phase(input sync_phase_t p);
        case (p)
            VISIBLE: next_phase = FRONT;
            FRONT:   next_phase = SYNC;
            SYNC:    next_phase = BACK;
            BACK:    next_phase = VISIBLE;
            default: next_phase = BACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// One raster axis: phase FSM with a phase-local down-counter plus an
// absolute position counter. Strobes mark entry into SYNC and into BACK.
module vga_axis_seq
    import vga_timing_pkg::*;
#(
    parameter int unsigned VIS_LEN   = 640,
    parameter int unsigned FRONT_LEN = 16,
    parameter int unsigned SYNC_LEN  = 96,
    parameter int unsigned BACK_LEN  = 48,
    parameter int unsigned POS_W     = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             advance,
    output logic [POS_W-1:0] pos,
    output logic             wrap,
    output logic             set_stb,
    output logic             rst_stb,
    output logic             in_sync,
    output logic             in_visible
);

    localparam int unsigned TOTAL = VIS_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] ZERO     = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] ONE      = {{(POS_W-1){1'b0}}, 1'b1};

    // Counter reload value for a phase (its length minus one).
    function automatic logic [POS_W-1:0] len_m1(input sync_phase_t p);
        case (p)
            VISIBLE: len_m1 = POS_W'(VIS_LEN - 1);
            FRONT:   len_m1 = POS_W'(FRONT_LEN - 1);
            SYNC:    len_m1 = POS_W'(SYNC_LEN - 1);
            BACK:    len_m1 = POS_W'(BACK_LEN - 1);
            default: len_m1 = POS_W'(BACK_LEN - 1);
        endcase
    endfunction

    sync_phase_t      phase_r;
    sync_phase_t      phase_next_s;
    logic [POS_W-1:0] cnt_r;
    logic [POS_W-1:0] cnt_next_s;
    logic [POS_W-1:0] pos_r;
    logic [POS_W-1:0] pos_next_s;
    logic             phase_end_s;
    logic             set_stb_r;
    logic             rst_stb_r;

    assign phase_end_s = (cnt_r == ZERO);

    // The axis wraps on the advance that leaves the last BACK position; the
    // next axis chains on this combinationally so both move on the same edge.
    assign wrap = advance && (phase_r == BACK) && phase_end_s;

    // Next-state logic for phase, phase-local counter and position.
    always_comb begin
        phase_next_s = phase_r;
        cnt_next_s   = cnt_r;
        pos_next_s   = pos_r;
        if (advance) begin
            if ((phase_r == BACK) && phase_end_s) begin
                pos_next_s = ZERO;
            end else begin
                pos_next_s = pos_r + ONE;
            end
            if (phase_end_s) begin
                phase_next_s = next_phase(phase_r);
                cnt_next_s   = len_m1(next_phase(phase_r));
            end else begin
                cnt_next_s   = cnt_r - ONE;
            end
        end else begin
            phase_next_s = phase_r;
            cnt_next_s   = cnt_r;
            pos_next_s   = pos_r;
        end
    end

    // State registers; reset parks the axis at its last BACK position so the
    // first advance lands on position 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_r   <= BACK;
            cnt_r     <= ZERO;
            pos_r     <= POS_LAST;
            set_stb_r <= 1'b0;
            rst_stb_r <= 1'b0;
        end else begin
            phase_r   <= phase_next_s;
            cnt_r     <= cnt_next_s;
            pos_r     <= pos_next_s;
            set_stb_r <= advance && (phase_r == FRONT) && phase_end_s;
            rst_stb_r <= advance && (phase_r == SYNC) && phase_end_s;
        end
    end

    assign pos        = pos_r;
    assign set_stb    = set_stb_r;
    assign rst_stb    = rst_stb_r;
    assign in_sync    = (phase_r == SYNC);
    assign in_visible = (phase_r == VISIBLE);

endmodule

// File: rtl/vga_sync_strobe_gen.sv
// VGA raster generator producing set/clear strobe pairs for external hsync
// and vsync SR latches, plus registered sync levels, coordinates, video_on
// and a frame-start pulse.
module vga_sync_strobe_gen #(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       hs_set,
    output logic       hs_reset,
    output logic       vs_set,
    output logic       vs_reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if ((H_TOT > MAX_TOTAL) || (V_TOT > MAX_TOTAL)) begin : g_total_check
            $error("vga_sync_strobe_gen: line or frame total exceeds 1024");
        end
    endgenerate

    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             h_set_s;
    logic             h_rst_s;
    logic             v_set_s;
    logic             v_rst_s;
    logic             h_sync_s;
    logic             v_sync_s;
    logic             h_vis_s;
    logic             v_vis_s;
    logic [POS_W-1:0] h_pos_s;
    logic [POS_W-1:0] v_pos_s;
    logic             rst_hold_r;
    logic             frame_start_r;

    vga_axis_seq #(
        .VIS_LEN   (H_VISIBLE),
        .FRONT_LEN (H_FRONT),
        .SYNC_LEN  (H_SYNC),
        .BACK_LEN  (H_BACK),
        .POS_W     (POS_W)
    ) u_h_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .advance    (enable),
        .pos        (h_pos_s),
        .wrap       (h_wrap_s),
        .set_stb    (h_set_s),
        .rst_stb    (h_rst_s),
        .in_sync    (h_sync_s),
        .in_visible (h_vis_s)
    );

    // The vertical axis steps once per line, on the edge where x wraps to 0.
    vga_axis_seq #(
        .VIS_LEN   (V_VISIBLE),
        .FRONT_LEN (V_FRONT),
        .SYNC_LEN  (V_SYNC),
        .BACK_LEN  (V_BACK),
        .POS_W     (POS_W)
    ) u_v_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .advance    (h_wrap_s),
        .pos        (v_pos_s),
        .wrap       (v_wrap_s),
        .set_stb    (v_set_s),
        .rst_stb    (v_rst_s),
        .in_sync    (v_sync_s),
        .in_visible (v_vis_s)
    );

    // Reset hold keeps both latch-clear strobes asserted for every reset edge;
    // frame_start fires when both axes wrap together into (0,0).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_hold_r    <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            rst_hold_r    <= 1'b0;
            frame_start_r <= v_wrap_s;
        end
    end

    assign hs_set      = h_set_s;
    assign hs_reset    = h_rst_s | rst_hold_r;
    assign vs_set      = v_set_s;
    assign vs_reset    = v_rst_s | rst_hold_r;
    assign hsync       = h_sync_s ? SYNC_POL : ~SYNC_POL;
    assign vsync       = v_sync_s ? SYNC_POL : ~SYNC_POL;
    assign video_on    = h_vis_s & v_vis_s;
    assign x           = h_pos_s;
    assign y           = v_pos_s;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_strobe_gen.sv
// Self-checking bench: a position-based reference model pushes the expected
// outputs for every driven cycle into a scoreboard that a monitor pops and
// compares after each edge. Feature tasks add their own targeted checks.
// Horizontal timing is the real 800-pixel line; the vertical axis is
// shortened (6/3/2/4 lines) so complete frames fit in a short run, while
// keeping a 2-line vsync.
module tb_vga_sync_strobe_gen;

    localparam int HT = 800, HV = 640, HSS = 656, HSE = 752;
    localparam int VV = 6, VF = 3, VSW = 2, VB = 4;
    localparam int VT = VV + VF + VSW + VB;
    localparam int VSS = VV + VF;
    localparam int VSE = VSS + VSW;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       hs_set, hs_reset, vs_set, vs_reset, hsync, vsync, video_on, frame_start;
    logic [9:0] x, y;

    typedef struct {
        logic hs_set, hs_reset, vs_set, vs_reset;
        logic hsync, vsync, video_on, frame_start;
        int   x, y;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   mx = HT - 1;
    int   my = VT - 1;

    always #5 clk = ~clk;

    vga_sync_strobe_gen #(
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB), .SYNC_POL (1'b0)
    ) dut (
        .clk (clk), .reset_n (reset_n), .enable (enable),
        .hs_set (hs_set), .hs_reset (hs_reset), .vs_set (vs_set), .vs_reset (vs_reset),
        .hsync (hsync), .vsync (vsync), .video_on (video_on),
        .x (x), .y (y), .frame_start (frame_start)
    );

    // Drive one clock of stimulus, push the model's expectation, return #1 after the edge.
    task automatic cyc(input logic en, input logic rn);
        exp_t e;
        int nx, ny;
        logic hw;
        @(negedge clk);
        enable  = en;
        reset_n = rn;
        e.hs_set = 1'b0; e.hs_reset = 1'b0; e.vs_set = 1'b0; e.vs_reset = 1'b0;
        e.frame_start = 1'b0;
        if (!rn) begin
            mx = HT - 1; my = VT - 1;
            e.hs_reset = 1'b1; e.vs_reset = 1'b1;
        end else if (en) begin
            hw = (mx == HT - 1);
            nx = hw ? 0 : mx + 1;
            ny = hw ? ((my == VT - 1) ? 0 : my + 1) : my;
            e.hs_set      = (nx == HSS);
            e.hs_reset    = (nx == HSE);
            e.vs_set      = hw && (ny == VSS);
            e.vs_reset    = hw && (ny == VSE);
            e.frame_start = (nx == 0) && (ny == 0);
            mx = nx; my = ny;
        end
        e.x = mx; e.y = my;
        e.hsync    = !((mx >= HSS) && (mx < HSE));
        e.vsync    = !((my >= VSS) && (my < VSE));
        e.video_on = (mx < HV) && (my < VV);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every output against the popped expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks += 10;
            if (hs_set !== mon_e.hs_set) $display("FAIL sb_hs_set t=%0t got %b want %b", $time, hs_set, mon_e.hs_set); else n_pass++;
            if (hs_reset !== mon_e.hs_reset) $display("FAIL sb_hs_reset t=%0t got %b want %b", $time, hs_reset, mon_e.hs_reset); else n_pass++;
            if (vs_set !== mon_e.vs_set) $display("FAIL sb_vs_set t=%0t got %b want %b", $time, vs_set, mon_e.vs_set); else n_pass++;
            if (vs_reset !== mon_e.vs_reset) $display("FAIL sb_vs_reset t=%0t got %b want %b", $time, vs_reset, mon_e.vs_reset); else n_pass++;
            if (hsync !== mon_e.hsync) $display("FAIL sb_hsync t=%0t got %b want %b", $time, hsync, mon_e.hsync); else n_pass++;
            if (vsync !== mon_e.vsync) $display("FAIL sb_vsync t=%0t got %b want %b", $time, vsync, mon_e.vsync); else n_pass++;
            if (video_on !== mon_e.video_on) $display("FAIL sb_video_on t=%0t got %b want %b", $time, video_on, mon_e.video_on); else n_pass++;
            if (frame_start !== mon_e.frame_start) $display("FAIL sb_frame_start t=%0t got %b want %b", $time, frame_start, mon_e.frame_start); else n_pass++;
            if (x !== 10'(mon_e.x)) $display("FAIL sb_x t=%0t got %0d want %0d", $time, x, mon_e.x); else n_pass++;
            if (y !== 10'(mon_e.y)) $display("FAIL sb_y t=%0t got %0d want %0d", $time, y, mon_e.y); else n_pass++;
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            n_checks++;
            if ({hs_reset, vs_reset, hsync, vsync, video_on, hs_set, vs_set} !== 7'b1111000)
                $display("FAIL reset_hold cyc=%0d got %b want 1111000", i, {hs_reset, vs_reset, hsync, vsync, video_on, hs_set, vs_set});
            else n_pass++;
            n_checks++;
            if ((x !== 10'd799) || (y !== 10'(VT - 1))) $display("FAIL reset_pos got (%0d,%0d) want (799,%0d)", x, y, VT - 1); else n_pass++;
        end
        cyc(1'b1, 1'b1);
        n_checks++;
        if ({x, y, frame_start, video_on, hs_reset, vs_reset} !== {10'd0, 10'd0, 4'b1100})
            $display("FAIL reset_release got x=%0d y=%0d fs=%b von=%b hr=%b vr=%b want 0 0 1 1 0 0", x, y, frame_start, video_on, hs_reset, vs_reset);
        else n_pass++;
    endtask

    task automatic test_hsync();
        int low = 0, n_set = 0, n_rst = 0, set_at = -1, rst_at = -1;
        for (int i = 0; i < HT; i++) begin
            cyc(1'b1, 1'b1);
            if (hsync === 1'b0) low++;
            if (hs_set === 1'b1) begin n_set++; set_at = i; end
            if (hs_reset === 1'b1) begin n_rst++; rst_at = i; end
            if (hs_set === 1'b1) begin
                n_checks++;
                if (x !== 10'd656) $display("FAIL hs_set_pos got %0d want 656", x); else n_pass++;
            end
        end
        n_checks++;
        if (low != 96) $display("FAIL hsync_low got %0d want 96", low); else n_pass++;
        n_checks++;
        if ((n_set != 1) || (n_rst != 1)) $display("FAIL hs_strobe_count got set=%0d rst=%0d want 1 1", n_set, n_rst); else n_pass++;
        n_checks++;
        if (rst_at - set_at != 96) $display("FAIL hs_strobe_gap got %0d want 96", rst_at - set_at); else n_pass++;
    endtask

    task automatic test_vsync();
        int low = 0, n_vs = 0, n_vr = 0, n_fs = 0, fs_at = -1, fs_gap = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b1, 1'b1);
            if (vsync === 1'b0) low++;
            if (vs_reset === 1'b1) n_vr++;
            if (vs_set === 1'b1) begin
                n_vs++;
                n_checks++;
                if ((x !== 10'd0) || (y !== 10'(VSS))) $display("FAIL vs_set_pos got (%0d,%0d) want (0,%0d)", x, y, VSS); else n_pass++;
            end
            if (frame_start === 1'b1) begin
                n_fs++;
                if (fs_at >= 0) fs_gap = i - fs_at;
                fs_at = i;
            end
        end
        n_checks++;
        if (low != 2 * 1600) $display("FAIL vsync_low got %0d want 3200", low); else n_pass++;
        n_checks++;
        if ((n_vs != 2) || (n_vr != 2)) $display("FAIL vs_strobe_count got set=%0d rst=%0d want 2 2", n_vs, n_vr); else n_pass++;
        n_checks++;
        if ((n_fs != 2) || (fs_gap != FRAME)) $display("FAIL frame_period got n=%0d gap=%0d want 2 %0d", n_fs, fs_gap, FRAME); else n_pass++;
    endtask

    task automatic test_enable_sparse();
        int low = 0, n_set = 0, n_rst = 0, wide = 0, moved = 0;
        logic prev_set = 1'b0, prev_rst = 1'b0;
        logic [9:0] prev_x;
        prev_x = x;
        for (int i = 0; i < 4 * HT; i++) begin
            cyc((i % 4) == 0, 1'b1);
            if (hsync === 1'b0) low++;
            if (hs_set === 1'b1) n_set++;
            if (hs_reset === 1'b1) n_rst++;
            if ((prev_set && hs_set) || (prev_rst && hs_reset)) wide++;
            if (((i % 4) != 0) && (x !== prev_x)) moved++;
            prev_set = hs_set; prev_rst = hs_reset; prev_x = x;
        end
        n_checks++;
        if (low != 384) $display("FAIL sparse_hsync_low got %0d want 384", low); else n_pass++;
        n_checks++;
        if ((n_set != 1) || (n_rst != 1) || (wide != 0)) $display("FAIL sparse_strobes got set=%0d rst=%0d wide=%0d want 1 1 0", n_set, n_rst, wide); else n_pass++;
        n_checks++;
        if (moved != 0) $display("FAIL sparse_hold got %0d moves want 0", moved); else n_pass++;
    endtask

    task automatic test_reset_mid_sync();
        int budget = 2 * FRAME;
        while (!((mx == 700) && (my == 3)) && (budget > 0)) begin
            cyc(1'b1, 1'b1);
            budget--;
        end
        n_checks++;
        if (budget == 0) $display("FAIL mid_sync_reach got (%0d,%0d) want (700,3)", mx, my); else n_pass++;
        n_checks++;
        if (hsync !== 1'b0) $display("FAIL mid_sync_level got %b want 0", hsync); else n_pass++;
        cyc(1'b1, 1'b0);
        n_checks++;
        if ({hsync, hs_reset, hs_set, vs_set} !== 4'b1100) $display("FAIL mid_reset_strobes got %b want 1100", {hsync, hs_reset, hs_set, vs_set}); else n_pass++;
        n_checks++;
        if ((x !== 10'd799) || (y !== 10'(VT - 1))) $display("FAIL mid_reset_pos got (%0d,%0d) want (799,%0d)", x, y, VT - 1); else n_pass++;
        cyc(1'b1, 1'b1);
        n_checks++;
        if ((x !== 10'd0) || (y !== 10'd0) || (frame_start !== 1'b1)) $display("FAIL mid_reset_resume got (%0d,%0d) fs=%b want (0,0) 1", x, y, frame_start); else n_pass++;
    endtask

    task automatic test_visibility();
        int seen = 0;
        for (int i = 0; i < VV * HT + 1; i++) begin
            cyc(1'b1, 1'b1);
            if ((mx == 639) && (my == 0)) begin
                seen++; n_checks++;
                if (video_on !== 1'b1) $display("FAIL vis_639_0 got %b want 1", video_on); else n_pass++;
            end
            if ((mx == 640) && (my == 0)) begin
                seen++; n_checks++;
                if (video_on !== 1'b0) $display("FAIL vis_640_0 got %b want 0", video_on); else n_pass++;
            end
            if ((mx == 0) && (my == VV - 1)) begin
                seen++; n_checks++;
                if (video_on !== 1'b1) $display("FAIL vis_0_last got %b want 1", video_on); else n_pass++;
            end
            if ((mx == 0) && (my == VV)) begin
                seen++; n_checks++;
                if (video_on !== 1'b0) $display("FAIL vis_0_below got %b want 0", video_on); else n_pass++;
            end
        end
        n_checks++;
        if (seen != 4) $display("FAIL vis_points_reached got %0d want 4", seen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_vsync();
        test_enable_sparse();
        test_reset_mid_sync();
        test_visibility();
        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drain got %0d left want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
